// File: rtl/eau_seq.sv
// eau_seq: two-way arbiter and load sequencer for the effective address unit.
// Grants the eau to fetch (0) or load/store (1). It writes the granted address
// low byte then high byte over the 8-bit bus, and skips the high-byte write
// when the cached high byte matches. It then holds the memory access open
// until mem_ready arrives or the timeout expires.
module eau_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] addr0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] addr1,
    output logic        ack1,
    output logic        err,
    output logic        gnt,
    output logic        busy,
    output logic [7:0]  d,
    output logic        wl,
    output logic        wh,
    output logic        oe,
    output logic        mem_valid,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADL  = 3'd1,
        LOADH  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Counter value seen in the last ACCESS cycle allowed before the abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_lat_q, addr_lat_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic        hi_valid_q, hi_valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_lat_q, err_lat_d;
    logic        pick_s;
    logic        hi_hit_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_lat_q <= 16'h0000;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            hi_byte_q  <= 8'h00;
            hi_valid_q <= 1'b0;
            cnt_q      <= 8'h00;
            err_lat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_lat_q <= addr_lat_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            hi_byte_q  <= hi_byte_d;
            hi_valid_q <= hi_valid_d;
            cnt_q      <= cnt_d;
            err_lat_q  <= err_lat_d;
        end
    end

    // Next-state logic: arbitration, byte-load sequencing, access timeout.
    always_comb begin
        state_d    = state_q;
        addr_lat_d = addr_lat_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        hi_byte_d  = hi_byte_q;
        hi_valid_d = hi_valid_q;
        cnt_d      = cnt_q;
        err_lat_d  = err_lat_q;
        // On a tie the requester that was not granted last time wins.
        pick_s     = (req0 && req1) ? ~last_q : req1;
        hi_hit_s   = hi_valid_q && (hi_byte_q == addr_lat_q[15:8]);
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d      = pick_s;
                    last_d     = pick_s;
                    addr_lat_d = pick_s ? addr1 : addr0;
                    state_d    = LOADL;
                end else begin
                    state_d = IDLE;
                end
            end
            LOADL: begin
                if (hi_hit_s) begin
                    cnt_d   = 8'h00;
                    state_d = ACCESS;
                end else begin
                    state_d = LOADH;
                end
            end
            LOADH: begin
                hi_byte_d  = addr_lat_q[15:8];
                hi_valid_d = 1'b1;
                cnt_d      = 8'h00;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (mem_ready) begin
                    err_lat_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        err_lat_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode from the state and the registered data.
    always_comb begin
        d         = 8'h00;
        wl        = 1'b0;
        wh        = 1'b0;
        oe        = 1'b0;
        mem_valid = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err       = 1'b0;
        busy      = (state_q != IDLE);
        gnt       = gnt_q;
        case (state_q)
            LOADL: begin
                d  = addr_lat_q[7:0];
                wl = 1'b1;
            end
            LOADH: begin
                d  = addr_lat_q[15:8];
                wh = 1'b1;
            end
            ACCESS: begin
                oe        = 1'b1;
                mem_valid = 1'b1;
            end
            DONE: begin
                ack0 = ~gnt_q;
                ack1 = gnt_q;
                err  = err_lat_q;
            end
            default: begin
                d = 8'h00;
            end
        endcase
    end

endmodule
